// File: rtl/sparse_feature_encoder.sv
// rtl/sparse_feature_encoder.sv - raster dense pixels in, packed sparse value/col/row frame out
// One frame per image_size^2 accepted pixels; output buses hold until the next frame completes.
module sparse_feature_encoder #(
  parameter int word_length        = 8,
  parameter int col_length         = 8,
  parameter int double_word_length = 16,
  parameter int image_size         = 7,
  parameter int max_nnz            = 52
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [word_length-1:0]              in_pixel,
  input  logic [double_word_length-1:0]       in_channel,
  output logic                                out_valid,
  output logic [double_word_length-1:0]       out_channel,
  output logic [double_word_length-1:0]       feature_valid_num,
  output logic [max_nnz*word_length-1:0]      feature_value,
  output logic [max_nnz*col_length-1:0]       feature_cols,
  output logic [max_nnz*col_length-1:0]       feature_rows,
  output logic                                overflow
);

  localparam logic [col_length-1:0]         LAST_IDX = col_length'(image_size - 1);
  localparam logic [double_word_length-1:0] MAX_CNT  = double_word_length'(max_nnz);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e state_q, state_d;

  logic [col_length-1:0]            col_q, col_d;
  logic [col_length-1:0]            row_q, row_d;
  logic [double_word_length-1:0]    cnt_q, cnt_d;
  logic                             ovf_q, ovf_d;
  logic [double_word_length-1:0]    ch_q, ch_d;
  logic [max_nnz*word_length-1:0]   wval_q, wval_d;
  logic [max_nnz*col_length-1:0]    wcol_q, wcol_d;
  logic [max_nnz*col_length-1:0]    wrow_q, wrow_d;

  logic [max_nnz*word_length-1:0]   oval_q, oval_d;
  logic [max_nnz*col_length-1:0]    ocol_q, ocol_d;
  logic [max_nnz*col_length-1:0]    orow_q, orow_d;
  logic [double_word_length-1:0]    onum_q, onum_d;
  logic [double_word_length-1:0]    och_q, och_d;
  logic                             oovf_q, oovf_d;

  logic accept;
  logic last_pix;

  assign accept   = in_valid && in_ready;
  // Coordinates return to zero after the last pixel, so they are already zero in IDLE.
  assign last_pix = (col_q == LAST_IDX) && (row_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = last_pix ? DONE : COLLECT;
      COLLECT: if (accept && last_pix) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    if (state_q == DONE) begin
      in_ready  = 1'b0;
      out_valid = 1'b1;
    end
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    ch_d   = ch_q;
    wval_d = wval_q;
    wcol_d = wcol_q;
    wrow_d = wrow_q;
    oval_d = oval_q;
    ocol_d = ocol_q;
    orow_d = orow_q;
    onum_d = onum_q;
    och_d  = och_q;
    oovf_d = oovf_q;
    if (accept) begin
      if (state_q == IDLE) begin
        cnt_d  = '0;
        ovf_d  = 1'b0;
        ch_d   = in_channel;
        wval_d = '0;
        wcol_d = '0;
        wrow_d = '0;
      end
      if (in_pixel != '0) begin
        if (cnt_d < MAX_CNT) begin
          for (int k = 0; k < max_nnz; k++) begin
            if (cnt_d == double_word_length'(k)) begin
              wval_d[k*word_length +: word_length] = in_pixel;
              wcol_d[k*col_length +: col_length]   = col_q;
              wrow_d[k*col_length +: col_length]   = row_q;
            end
          end
          cnt_d = cnt_d + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // Outputs take the buffer as it stands after this pixel, so a nonzero last pixel is included.
      if (last_pix) begin
        oval_d = wval_d;
        ocol_d = wcol_d;
        orow_d = wrow_d;
        onum_d = cnt_d;
        och_d  = ch_d;
        oovf_d = ovf_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      ch_q   <= '0;
      wval_q <= '0;
      wcol_q <= '0;
      wrow_q <= '0;
      oval_q <= '0;
      ocol_q <= '0;
      orow_q <= '0;
      onum_q <= '0;
      och_q  <= '0;
      oovf_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      ch_q   <= ch_d;
      wval_q <= wval_d;
      wcol_q <= wcol_d;
      wrow_q <= wrow_d;
      oval_q <= oval_d;
      ocol_q <= ocol_d;
      orow_q <= orow_d;
      onum_q <= onum_d;
      och_q  <= och_d;
      oovf_q <= oovf_d;
    end
  end

  assign feature_value     = oval_q;
  assign feature_cols      = ocol_q;
  assign feature_rows      = orow_q;
  assign feature_valid_num = onum_q;
  assign out_channel       = och_q;
  assign overflow          = oovf_q;

endmodule

// File: tb/tb_sparse_feature_encoder.sv
// tb/tb_sparse_feature_encoder.sv - self-checking bench for sparse_feature_encoder
// Two instances share stimulus: default depth 52 and a shallow depth 40 that overflows.
module tb_sparse_feature_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid;
  logic [7:0]  in_pixel;
  logic [15:0] in_channel;

  logic         rdy_a, ov_a, ovf_a;
  logic [15:0]  ch_a, num_a;
  logic [415:0] val_a, cols_a, rows_a;
  logic         rdy_b, ov_b, ovf_b;
  logic [15:0]  ch_b, num_b;
  logic [319:0] val_b, cols_b, rows_b;

  sparse_feature_encoder dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_pixel(in_pixel),
    .in_channel(in_channel), .out_valid(ov_a), .out_channel(ch_a), .feature_valid_num(num_a),
    .feature_value(val_a), .feature_cols(cols_a), .feature_rows(rows_a), .overflow(ovf_a)
  );

  sparse_feature_encoder #(.max_nnz(40)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_pixel(in_pixel),
    .in_channel(in_channel), .out_valid(ov_b), .out_channel(ch_b), .feature_valid_num(num_b),
    .feature_value(val_b), .feature_cols(cols_b), .feature_rows(rows_b), .overflow(ovf_b)
  );

  int checks = 0;
  int errors = 0;
  int dens   = 50;

  logic [7:0]   frame_px [49];
  int           exp_n_a, exp_n_b;
  logic [415:0] exp_v_a, exp_c_a, exp_r_a, exp_v_b, exp_c_b, exp_r_b;
  bit           exp_ovf_a, exp_ovf_b;
  logic [15:0]  exp_ch;

  typedef struct {
    int          kind;
    logic [15:0] ch;
    bit          gap;
    bit          b2b;
    int          nnz_a;
    int          nnz_b;
    bit          ovf_b;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [415:0] act, input logic [415:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: walk the raster by flat index, keep nonzeros in order until the list is full.
  task automatic model(input int maxn, output int n, output logic [415:0] v, c, r, output bit ov);
    n = 0; v = '0; c = '0; r = '0; ov = 1'b0;
    for (int idx = 0; idx < 49; idx++) begin
      if (frame_px[idx] != 8'd0) begin
        if (n < maxn) begin
          v[n*8 +: 8] = frame_px[idx];
          c[n*8 +: 8] = 8'(idx % 7);
          r[n*8 +: 8] = 8'(idx / 7);
          n++;
        end else begin
          ov = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_expect();
    exp_n_a = 0; exp_n_b = 0; exp_ovf_a = 0; exp_ovf_b = 0; exp_ch = '0;
    exp_v_a = '0; exp_c_a = '0; exp_r_a = '0; exp_v_b = '0; exp_c_b = '0; exp_r_b = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " num_a"},  416'(num_a),  416'(exp_n_a));
    chk({tag, " val_a"},  val_a,        exp_v_a);
    chk({tag, " cols_a"}, cols_a,       exp_c_a);
    chk({tag, " rows_a"}, rows_a,       exp_r_a);
    chk({tag, " ch_a"},   416'(ch_a),   416'(exp_ch));
    chk({tag, " ovf_a"},  416'(ovf_a),  416'(exp_ovf_a));
    chk({tag, " num_b"},  416'(num_b),  416'(exp_n_b));
    chk({tag, " val_b"},  416'(val_b),  exp_v_b);
    chk({tag, " cols_b"}, 416'(cols_b), exp_c_b);
    chk({tag, " rows_b"}, 416'(rows_b), exp_r_b);
    chk({tag, " ch_b"},   416'(ch_b),   416'(exp_ch));
    chk({tag, " ovf_b"},  416'(ovf_b),  416'(exp_ovf_b));
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < 49; i++) begin
      case (kind)
        2:       frame_px[i] = 8'(i + 1);
        4:       frame_px[i] = ($urandom_range(0, 99) < dens) ? 8'($urandom) : 8'd0;
        default: frame_px[i] = 8'd0;
      endcase
    end
    if (kind == 0) begin
      frame_px[0] = 8'd5; frame_px[25] = 8'hFE; frame_px[48] = 8'd7;
    end
    if (kind == 3) begin
      frame_px[10] = 8'h80; frame_px[30] = 8'h01;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    clear_expect();
    chk("reset in_ready", 416'(rdy_a), 416'(1));
    chk("reset out_valid", 416'(ov_a), 416'(0));
    check_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] ch, input bit gap, input bit b2b);
    int waits;
    int wc;
    waits = 0;
    for (int i = 0; i < 49; i++) begin
      if (gap && i > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_pixel = 8'($urandom);
      end
      @(negedge clk);
      if (i == 0)  chk("pulse_end", 416'(ov_a), 416'(0));
      if (i == 25) check_outputs("hold");
      if (i == 48) chk("early_valid", 416'(ov_a), 416'(0));
      in_valid   = 1'b1;
      in_pixel   = frame_px[i];
      in_channel = (i == 0) ? ch : 16'($urandom);
      wc = 0;
      while (!rdy_a && wc < 4) begin
        waits++;
        wc++;
        @(negedge clk);
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("done out_valid_a", 416'(ov_a), 416'(1));
    chk("done out_valid_b", 416'(ov_b), 416'(1));
    chk("done in_ready_a", 416'(rdy_a), 416'(0));
    chk("done in_ready_b", 416'(rdy_b), 416'(0));
    model(52, exp_n_a, exp_v_a, exp_c_a, exp_r_a, exp_ovf_a);
    model(40, exp_n_b, exp_v_b, exp_c_b, exp_r_b, exp_ovf_b);
    exp_ch = ch;
    check_outputs("frame");
    chk("ready_stall", 416'(waits), 416'(0));
    // A pixel offered during DONE must be ignored; the next frame re-offers its own pixel 0.
    in_valid = b2b;
    in_pixel = 8'd99;
    if (!b2b) begin
      @(negedge clk);
      chk("pulse_len", 416'(ov_a), 416'(0));
    end
  endtask

  initial begin
    tbl[0] = '{kind: 0, ch: 16'd3,      gap: 0, b2b: 0, nnz_a: 3,  nnz_b: 3,  ovf_b: 0};
    tbl[1] = '{kind: 1, ch: 16'd9,      gap: 0, b2b: 0, nnz_a: 0,  nnz_b: 0,  ovf_b: 0};
    tbl[2] = '{kind: 2, ch: 16'h1234,   gap: 1, b2b: 0, nnz_a: 49, nnz_b: 40, ovf_b: 1};
    tbl[3] = '{kind: 3, ch: 16'd5,      gap: 0, b2b: 1, nnz_a: 2,  nnz_b: 2,  ovf_b: 0};
    tbl[4] = '{kind: 0, ch: 16'd7,      gap: 0, b2b: 1, nnz_a: 3,  nnz_b: 3,  ovf_b: 0};
    tbl[5] = '{kind: 2, ch: 16'hFFFF,   gap: 0, b2b: 0, nnz_a: 49, nnz_b: 40, ovf_b: 1};

    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; in_channel = '0;
    clear_expect();
    repeat (2) @(negedge clk);
    do_reset();

    for (int e = 0; e < 6; e++) begin
      fill(tbl[e].kind);
      run_frame(tbl[e].ch, tbl[e].gap, tbl[e].b2b);
      chk("table nnz_a", 416'(num_a), 416'(tbl[e].nnz_a));
      chk("table nnz_b", 416'(num_b), 416'(tbl[e].nnz_b));
      chk("table ovf_b", 416'(ovf_b), 416'(tbl[e].ovf_b));
      chk("table ovf_a", 416'(ovf_a), 416'(0));
    end

    for (int r = 0; r < 8; r++) begin
      dens = $urandom_range(0, 100);
      fill(4);
      run_frame(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    fill(2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_pixel = frame_px[i];
      in_channel = 16'd77;
      @(posedge clk);
    end
    do_reset();
    fill(0);
    run_frame(16'd11, 1'b0, 1'b0);
    chk("fresh nnz_a", 416'(num_a), 416'(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
